// File: rtl/instruction_decode.sv
// RV32I decode stage: registers the decoded fields of the fetched instruction for execute.
// Flush inserts a one-cycle bubble; stall is passed straight through to fetch.
module instruction_decode #(
  parameter int IWIDTH     = 32,
  parameter int PC_WIDTH   = 32,
  parameter int REG_AWIDTH = 5
) (
  input  logic                  d_clk,
  input  logic                  d_rst,
  input  logic [IWIDTH-1:0]     d_i_instr,
  input  logic [PC_WIDTH-1:0]   d_i_pc,
  input  logic                  d_i_ce,
  input  logic                  d_i_stall,
  input  logic                  d_i_flush,
  output logic                  d_o_stall,
  output logic                  d_o_flush,
  output logic                  d_o_ce,
  output logic [PC_WIDTH-1:0]   d_o_pc,
  output logic [IWIDTH-1:0]     d_o_instr,
  output logic [6:0]            d_o_opcode,
  output logic [2:0]            d_o_funct3,
  output logic [REG_AWIDTH-1:0] d_o_rs1_addr,
  output logic [REG_AWIDTH-1:0] d_o_rs2_addr,
  output logic [REG_AWIDTH-1:0] d_o_rd_addr,
  output logic [31:0]           d_o_imm,
  output logic [3:0]            d_o_alu_op,
  output logic                  d_o_illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // R-type and I-ALU share the funct3 map; only R-type can select SUB.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3,
                                                 input logic       bit30,
                                                 input logic       is_reg);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (is_reg && bit30) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = bit30 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Immediate formats, all sign-extended from bit 31.
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic [2:0]  funct3;

  assign funct3 = d_i_instr[14:12];
  assign imm_i  = {{20{d_i_instr[31]}}, d_i_instr[31:20]};
  assign imm_s  = {{20{d_i_instr[31]}}, d_i_instr[31:25], d_i_instr[11:7]};
  assign imm_b  = {{19{d_i_instr[31]}}, d_i_instr[31], d_i_instr[7],
                   d_i_instr[30:25], d_i_instr[11:8], 1'b0};
  assign imm_u  = {d_i_instr[31:12], 12'b0};
  assign imm_j  = {{11{d_i_instr[31]}}, d_i_instr[31], d_i_instr[19:12],
                   d_i_instr[20], d_i_instr[30:21], 1'b0};
  assign imm_sh = {27'b0, d_i_instr[24:20]};

  logic [REG_AWIDTH-1:0] dec_rs1, dec_rs2, dec_rd;
  logic [31:0]           dec_imm;
  logic [3:0]            dec_alu_op;
  logic                  dec_illegal;

  // NOTE: every combinational output gets a default before the case so no path
  // leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    dec_rs1     = REG_AWIDTH'(d_i_instr[19:15]);
    dec_rs2     = '0;
    dec_rd      = REG_AWIDTH'(d_i_instr[11:7]);
    dec_imm     = '0;
    dec_alu_op  = ALU_ADD;
    dec_illegal = 1'b0;
    case (d_i_instr[6:0])
      OP_R: begin
        dec_rs2    = REG_AWIDTH'(d_i_instr[24:20]);
        dec_alu_op = alu_from_funct3(funct3, d_i_instr[30], 1'b1);
      end
      OP_IMM: begin
        dec_imm    = (funct3 == 3'b001 || funct3 == 3'b101) ? imm_sh : imm_i;
        dec_alu_op = alu_from_funct3(funct3, d_i_instr[30], 1'b0);
      end
      OP_LOAD, OP_JALR, OP_SYSTEM: dec_imm = imm_i;
      OP_STORE: begin
        dec_rs2 = REG_AWIDTH'(d_i_instr[24:20]);
        dec_rd  = '0;
        dec_imm = imm_s;
      end
      OP_BRANCH: begin
        dec_rs2    = REG_AWIDTH'(d_i_instr[24:20]);
        dec_rd     = '0;
        dec_imm    = imm_b;
        dec_alu_op = ALU_SUB;
      end
      OP_LUI, OP_AUIPC: begin
        dec_rs1 = '0;
        dec_imm = imm_u;
      end
      OP_JAL: begin
        dec_rs1 = '0;
        dec_imm = imm_j;
      end
      OP_FENCE: dec_rd = '0;
      default: begin
        // Unknown opcode: present a harmless bundle and let execute trap.
        dec_rs1     = '0;
        dec_rd      = '0;
        dec_illegal = 1'b1;
      end
    endcase
  end

  logic                  ce_d, ce_q;
  logic                  flush_d, flush_q;
  logic [PC_WIDTH-1:0]   pc_d, pc_q;
  logic [IWIDTH-1:0]     instr_d, instr_q;
  logic [6:0]            opcode_d, opcode_q;
  logic [2:0]            funct3_d, funct3_q;
  logic [REG_AWIDTH-1:0] rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
  logic [31:0]           imm_d, imm_q;
  logic [3:0]            alu_op_d, alu_op_q;
  logic                  illegal_d, illegal_q;

  // Priority: flush > stall > capture (reset handled in the register block).
  always_comb begin
    ce_d      = ce_q;
    flush_d   = flush_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    opcode_d  = opcode_q;
    funct3_d  = funct3_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    imm_d     = imm_q;
    alu_op_d  = alu_op_q;
    illegal_d = illegal_q;
    if (d_i_flush) begin
      ce_d    = 1'b0;
      flush_d = 1'b1;
    end else if (!d_i_stall) begin
      ce_d    = d_i_ce;
      flush_d = 1'b0;
      if (d_i_ce) begin
        pc_d      = d_i_pc;
        instr_d   = d_i_instr;
        opcode_d  = d_i_instr[6:0];
        funct3_d  = funct3;
        rs1_d     = dec_rs1;
        rs2_d     = dec_rs2;
        rd_d      = dec_rd;
        imm_d     = dec_imm;
        alu_op_d  = dec_alu_op;
        illegal_d = dec_illegal;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge d_clk) begin
    if (d_rst) begin
      ce_q      <= 1'b0;
      flush_q   <= 1'b0;
      pc_q      <= '0;
      instr_q   <= '0;
      opcode_q  <= '0;
      funct3_q  <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      alu_op_q  <= ALU_ADD;
      illegal_q <= 1'b0;
    end else begin
      ce_q      <= ce_d;
      flush_q   <= flush_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      opcode_q  <= opcode_d;
      funct3_q  <= funct3_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      imm_q     <= imm_d;
      alu_op_q  <= alu_op_d;
      illegal_q <= illegal_d;
    end
  end

  assign d_o_stall    = d_i_stall;
  assign d_o_flush    = flush_q;
  assign d_o_ce       = ce_q;
  assign d_o_pc       = pc_q;
  assign d_o_instr    = instr_q;
  assign d_o_opcode   = opcode_q;
  assign d_o_funct3   = funct3_q;
  assign d_o_rs1_addr = rs1_q;
  assign d_o_rs2_addr = rs2_q;
  assign d_o_rd_addr  = rd_q;
  assign d_o_imm      = imm_q;
  assign d_o_alu_op   = alu_op_q;
  assign d_o_illegal  = illegal_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboard bench for instruction_decode: the driver pushes the expected output
// bundle per cycle, an independent monitor pops and compares after each edge.
module tb_instruction_decode;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        illegal;
  } dec_t;

  typedef struct packed {
    logic        ce;
    logic        flush;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] instr;
    dec_t        d;
  } exp_t;

  logic        d_clk = 1'b0;
  logic        d_rst = 1'b1;
  logic [31:0] d_i_instr = '0;
  logic [31:0] d_i_pc = '0;
  logic        d_i_ce = 1'b0;
  logic        d_i_stall = 1'b0;
  logic        d_i_flush = 1'b0;
  logic        d_o_stall, d_o_flush, d_o_ce, d_o_illegal;
  logic [31:0] d_o_pc, d_o_instr, d_o_imm;
  logic [6:0]  d_o_opcode;
  logic [2:0]  d_o_funct3;
  logic [4:0]  d_o_rs1_addr, d_o_rs2_addr, d_o_rd_addr;
  logic [3:0]  d_o_alu_op;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  exp_t cur = '0;

  instruction_decode #(.IWIDTH(32), .PC_WIDTH(32), .REG_AWIDTH(5)) dut (
    .d_clk(d_clk), .d_rst(d_rst),
    .d_i_instr(d_i_instr), .d_i_pc(d_i_pc), .d_i_ce(d_i_ce),
    .d_i_stall(d_i_stall), .d_i_flush(d_i_flush),
    .d_o_stall(d_o_stall), .d_o_flush(d_o_flush), .d_o_ce(d_o_ce),
    .d_o_pc(d_o_pc), .d_o_instr(d_o_instr), .d_o_opcode(d_o_opcode),
    .d_o_funct3(d_o_funct3), .d_o_rs1_addr(d_o_rs1_addr),
    .d_o_rs2_addr(d_o_rs2_addr), .d_o_rd_addr(d_o_rd_addr),
    .d_o_imm(d_o_imm), .d_o_alu_op(d_o_alu_op), .d_o_illegal(d_o_illegal)
  );

  always #5 d_clk = ~d_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic dec_t mk(input logic [6:0] op, input logic [2:0] f3,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [31:0] imm,
                              input logic [3:0] alu, input logic ill);
    dec_t r;
    r.opcode = op; r.funct3 = f3; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
    r.imm = imm; r.alu = alu; r.illegal = ill;
    return r;
  endfunction

  // Drive one cycle of inputs on the falling edge and queue the bundle expected after
  // the following rising edge, applying reset > flush > stall > capture.
  task automatic step(input logic rst, input logic ce, input logic stall, input logic flush,
                      input logic [31:0] instr, input logic [31:0] pc, input dec_t d);
    @(negedge d_clk);
    d_rst = rst; d_i_ce = ce; d_i_stall = stall; d_i_flush = flush;
    d_i_instr = instr; d_i_pc = pc;
    if (rst) begin
      cur = '0;
    end else if (flush) begin
      cur.ce = 1'b0;
      cur.flush = 1'b1;
    end else if (!stall) begin
      cur.ce = ce;
      cur.flush = 1'b0;
      if (ce) begin
        cur.pc = pc;
        cur.instr = instr;
        cur.d = d;
      end
    end
    cur.stall = stall;
    sb.push_back(cur);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge d_clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("stall",   {31'b0, d_o_stall},   {31'b0, e.stall});
        check("ce",      {31'b0, d_o_ce},      {31'b0, e.ce});
        check("flush",   {31'b0, d_o_flush},   {31'b0, e.flush});
        check("illegal", {31'b0, d_o_illegal}, {31'b0, e.d.illegal});
        check("pc",      d_o_pc,               e.pc);
        check("instr",   d_o_instr,            e.instr);
        check("opcode",  {25'b0, d_o_opcode},  {25'b0, e.d.opcode});
        check("funct3",  {29'b0, d_o_funct3},  {29'b0, e.d.funct3});
        check("rs1",     {27'b0, d_o_rs1_addr}, {27'b0, e.d.rs1});
        check("rs2",     {27'b0, d_o_rs2_addr}, {27'b0, e.d.rs2});
        check("rd",      {27'b0, d_o_rd_addr},  {27'b0, e.d.rd});
        check("imm",     d_o_imm,              e.d.imm);
        check("alu_op",  {28'b0, d_o_alu_op},  {28'b0, e.d.alu});
      end
    end
  end

  initial begin : driver
    dec_t none, addi5, sub, srai, beq, lui, sw, jal, ill, addim1;
    none   = '0;
    addi5  = mk(7'h13, 3'd0, 5'd0, 5'd0, 5'd1, 32'h0000_0005, 4'd0, 1'b0); // addi x1,x0,5
    sub    = mk(7'h33, 3'd0, 5'd1, 5'd2, 5'd3, 32'h0000_0000, 4'd1, 1'b0); // sub x3,x1,x2
    srai   = mk(7'h13, 3'd5, 5'd1, 5'd0, 5'd4, 32'h0000_0003, 4'd7, 1'b0); // srai x4,x1,3
    beq    = mk(7'h63, 3'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFF8, 4'd1, 1'b0); // beq x1,x2,-8
    lui    = mk(7'h37, 3'd5, 5'd0, 5'd0, 5'd5, 32'h1234_5000, 4'd0, 1'b0); // lui x5,0x12345
    sw     = mk(7'h23, 3'd2, 5'd1, 5'd2, 5'd0, 32'h0000_0008, 4'd0, 1'b0); // sw x2,8(x1)
    jal    = mk(7'h6F, 3'd0, 5'd0, 5'd0, 5'd1, 32'h0000_0010, 4'd0, 1'b0); // jal x1,16
    ill    = mk(7'h7F, 3'd7, 5'd0, 5'd0, 5'd0, 32'h0000_0000, 4'd0, 1'b1); // 0xFFFFFFFF
    addim1 = mk(7'h13, 3'd0, 5'd0, 5'd0, 5'd6, 32'hFFFF_FFFF, 4'd0, 1'b0); // addi x6,x0,-1

    // Reset with random inputs
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, none);
    step(0, 1, 0, 0, 32'h0050_0093, 32'h0000_0000, addi5);

    // Decode patterns back to back
    step(0, 1, 0, 0, 32'h4020_81B3, 32'h0000_0004, sub);
    step(0, 1, 0, 0, 32'h4030_D213, 32'h0000_0008, srai);
    step(0, 1, 0, 0, 32'hFE20_8CE3, 32'h0000_000C, beq);
    step(0, 1, 0, 0, 32'h1234_52B7, 32'h0000_0010, lui);

    // Stall freezes the bundle while fetch's word keeps changing
    step(0, 1, 0, 0, 32'h0050_0093, 32'h0000_0014, addi5);
    step(0, 1, 1, 0, 32'h4020_81B3, 32'h0000_0018, sub);
    step(0, 1, 1, 0, 32'h1234_52B7, 32'h0000_001C, lui);
    step(0, 1, 1, 0, 32'h0020_A423, 32'h0000_0020, sw);
    step(0, 1, 0, 0, 32'h0020_A423, 32'h0000_0018, sw);

    // Bubble: ce low, data hold
    step(0, 0, 0, 0, 32'h4020_81B3, 32'h0000_0040, sub);

    // Flush beats simultaneous stall and ce, then clears
    step(0, 1, 1, 1, 32'h4020_81B3, 32'h0000_0044, sub);
    step(0, 1, 0, 0, 32'h0100_00EF, 32'h0000_0080, jal);

    // Illegal opcode, then a legal instruction clears the flag
    step(0, 1, 0, 0, 32'hFFFF_FFFF, 32'h0000_0084, ill);
    step(0, 1, 0, 0, 32'hFFF0_0313, 32'h0000_0088, addim1);

    // Reset in the middle of stall and flush wins
    step(0, 1, 0, 0, 32'h4030_D213, 32'h0000_008C, srai);
    step(0, 1, 1, 0, 32'h4020_81B3, 32'h0000_0090, sub);
    step(1, 1, 1, 1, 32'h4020_81B3, 32'h0000_0090, sub);
    step(0, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, none);
    step(0, 1, 0, 0, 32'h0050_0093, 32'h0000_0100, addi5);

    repeat (3) @(posedge d_clk);
    #3;
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
